// File: rtl/decode_stage.sv
// decode_stage: one-entry RV32I decode slot; instructions are decoded at capture and held in registers.
// Optional register scoreboard (busy bits + RAW stall) is compiled in with DECODE_SCOREBOARD_EN.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic [31:0] imm,
    output logic [31:0] id_pc,
    output logic        illegal,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Handshakes: a transfer happens on a rising edge where valid && ready on that side.
    // Valid never depends on ready; if_ready depends combinationally on id_ready so a
    // full slot can drain and refill in the same cycle.

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] dec_imm;
    logic        dec_writes;
    logic        dec_reg_write;
    logic        dec_uses_rs1;
    logic        dec_uses_rs2;
    logic        dec_illegal;

    always_comb begin
        opcode = if_instr[6:0];
        imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
        imm_s  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        imm_b  = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
        imm_u  = {if_instr[31:12], 12'h000};
        imm_j  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

        dec_imm      = 32'h0;
        dec_writes   = 1'b0;
        dec_uses_rs1 = 1'b0;
        dec_uses_rs2 = 1'b0;
        dec_illegal  = 1'b0;

        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_imm    = imm_u;
                dec_writes = 1'b1;
            end
            OP_JAL: begin
                dec_imm    = imm_j;
                dec_writes = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                dec_imm      = imm_i;
                dec_writes   = 1'b1;
                dec_uses_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm      = imm_b;
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                dec_imm      = imm_s;
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
            end
            OP_OP: begin
                dec_writes   = 1'b1;
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        // Writes to x0 are architecturally discarded, so they never claim a register.
        dec_reg_write = dec_writes && (if_instr[11:7] != 5'd0);
    end

    // ------------------------------------------------------------------
    // Slot state and registered decode results
    // ------------------------------------------------------------------
    logic        slot_valid_q, slot_valid_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        illegal_q, illegal_d;
    logic        uses_rs1_q, uses_rs1_d;
    logic        uses_rs2_q, uses_rs2_d;

    logic        hazard;
    logic        fire;
    logic        accept;

    assign id_valid = slot_valid_q && !hazard;
    assign fire     = id_valid && id_ready;

    always_comb begin
        if_ready = !reset && !flush && (!slot_valid_q || fire);
        accept   = if_valid && if_ready;

        slot_valid_d = slot_valid_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        imm_d        = imm_q;
        id_pc_d      = id_pc_q;
        illegal_d    = illegal_q;
        uses_rs1_d   = uses_rs1_q;
        uses_rs2_d   = uses_rs2_q;

        // accept is already blocked during flush, so the ordering here only matters for clarity.
        if (flush) begin
            slot_valid_d = 1'b0;
        end else if (accept) begin
            slot_valid_d = 1'b1;
        end else if (fire) begin
            slot_valid_d = 1'b0;
        end

        if (accept) begin
            rs1_d       = if_instr[19:15];
            rs2_d       = if_instr[24:20];
            rd_d        = if_instr[11:7];
            reg_write_d = dec_reg_write;
            imm_d       = dec_imm;
            id_pc_d     = if_pc;
            illegal_d   = dec_illegal;
            uses_rs1_d  = dec_uses_rs1;
            uses_rs2_d  = dec_uses_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_q <= 1'b0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            imm_q        <= 32'h0;
            id_pc_q      <= 32'h0;
            illegal_q    <= 1'b0;
            uses_rs1_q   <= 1'b0;
            uses_rs2_q   <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            imm_q        <= imm_d;
            id_pc_q      <= id_pc_d;
            illegal_q    <= illegal_d;
            uses_rs1_q   <= uses_rs1_d;
            uses_rs2_q   <= uses_rs2_d;
        end
    end

    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign reg_write = reg_write_q;
    assign imm       = imm_q;
    assign id_pc     = id_pc_q;
    assign illegal   = illegal_q;

    // ------------------------------------------------------------------
    // Register scoreboard
    // ------------------------------------------------------------------
`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        // Issue of a new writer beats a retiring writeback to the same register.
        if (fire && reg_write_q) begin
            busy_d[rd_q] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 32'h0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Uses registered busy only: a writeback in this cycle releases the stall next cycle.
    assign hazard = slot_valid_q &&
                    ((uses_rs1_q && busy_q[rs1_q]) || (uses_rs2_q && busy_q[rs2_q]));
`else
    logic unused_sb;

    assign hazard    = 1'b0;
    assign unused_sb = &{1'b0, wb_valid, wb_rd, uses_rs1_q, uses_rs2_q};
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage; expected decodes come from a spec-level model,
// a separate monitor checks handshakes, held outputs and (with DECODE_SCOREBOARD_EN) hazard stalls.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        if_ready;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] imm;
    logic [31:0] id_pc;
    logic        illegal;
    logic        flush = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;

    decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_ready  (if_ready),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .imm       (imm),
        .id_pc     (id_pc),
        .illegal   (illegal),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model and scoreboard ----------------
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
        logic        u1;
        logic        u2;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mbusy = 32'h0;   // registers with an issued, not yet retired writer
    int          checks = 0;
    int          errors = 0;
    bit          wb_auto = 1'b0;
    bit          rdy_auto = 1'b0;

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        bit   writes;
        e.rs1     = ins[19:15];
        e.rs2     = ins[24:20];
        e.rd      = ins[11:7];
        e.pc      = pc;
        e.imm     = 32'h0;
        e.illegal = 1'b0;
        e.u1      = 1'b1;
        e.u2      = 1'b0;
        writes    = 1'b1;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin e.imm = ins & 32'hFFFFF000; e.u1 = 1'b0; end
            7'b1101111: begin
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                e.u1  = 1'b0;
            end
            7'b1100111, 7'b0000011, 7'b0010011: e.imm = 32'($signed(ins[31:20]));
            7'b1100011: begin
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                e.u2 = 1'b1; writes = 1'b0;
            end
            7'b0100011: begin
                e.imm = 32'($signed({ins[31:25], ins[11:7]}));
                e.u2 = 1'b1; writes = 1'b0;
            end
            7'b0110011: e.u2 = 1'b1;
            default: begin e.illegal = 1'b1; e.u1 = 1'b0; writes = 1'b0; end
        endcase
        e.reg_write = writes && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 2 ns after each falling edge, i.e. mid-cycle before the next rising edge.
    initial begin : monitor
        exp_t f;
        bit   slot;
        bit   haz;
        bit   efire;
        int   set_idx;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                chk("if_ready_in_reset", if_ready, 0);
                exp_q.delete();
                mbusy = 32'h0;
            end else begin
                slot    = exp_q.size() != 0;
                f       = '0;
                haz     = 1'b0;
                set_idx = 0;
                if (slot) f = exp_q[0];
`ifdef DECODE_SCOREBOARD_EN
                if (slot) haz = (f.u1 && mbusy[f.rs1]) || (f.u2 && mbusy[f.rs2]);
`endif
                chk("id_valid", id_valid, slot && !haz);
                efire = slot && !haz && id_ready;
                chk("if_ready", if_ready, !flush && (!slot || efire));
                if (slot) begin
                    chk("rs1", rs1, f.rs1);
                    chk("rs2", rs2, f.rs2);
                    chk("rd", rd, f.rd);
                    chk("reg_write", reg_write, f.reg_write);
                    chk("imm", imm, f.imm);
                    chk("id_pc", id_pc, f.pc);
                    chk("illegal", illegal, f.illegal);
                end
                if (efire) begin
                    if (f.reg_write) set_idx = int'(f.rd);
                    void'(exp_q.pop_front());
                end
                if (wb_valid) mbusy[wb_rd] = 1'b0;
                if (set_idx != 0) mbusy[set_idx] = 1'b1;
            end
        end
    end

    // ---------------- background drivers ----------------
    initial begin : wb_driver
        int cand[$];
        forever begin
            @(negedge clk);
            if (wb_auto) begin
                cand.delete();
                for (int i = 1; i < 32; i++) if (mbusy[i]) cand.push_back(i);
                wb_valid = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    wb_valid = 1'b1;
                    if (cand.size() != 0)
                        wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                    else
                        wb_rd = 5'($urandom_range(0, 31));
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(negedge clk);
            if (rdy_auto) id_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks (called and return on a falling edge) ----------------
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, output int waited);
        bit accepted;
        accepted = 1'b0;
        waited   = 0;
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        while (!accepted && waited <= 200) begin
            #3;
            if (if_ready) begin
                exp_q.push_back(ref_decode(ins, pc));
                accepted = 1'b1;
            end
            @(negedge clk);
            if (!accepted) waited++;
        end
        if (!accepted) chk("send_timeout", 1, 0);
        if_valid = 1'b0;
    endtask

    task automatic do_flush(input bit with_valid, input logic [31:0] ins);
        flush    = 1'b1;
        if_valid = with_valid;
        if_instr = ins;
        @(negedge clk);
        flush    = 1'b0;
        if_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic wb_pulse(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [6:0] ops[11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'h7F, 7'h00};

    initial begin : main
        int          w;
        int          n;
        logic [31:0] ins;

        // reset with a pending offer: nothing may be accepted
        reset    = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h00500093;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rs1", rs1, 0);
        chk("rst_rs2", rs2, 0);
        chk("rst_imm", imm, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clk);
        reset    = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);

        // addi x1,x0,5: one-cycle latency
        id_ready = 1'b1;
        send(32'h00500093, 32'h100, w);
        #1;
        chk("addi_id_valid", id_valid, 1);
        chk("addi_rd", rd, 1);
        chk("addi_rs1", rs1, 0);
        chk("addi_imm", imm, 5);
        chk("addi_reg_write", reg_write, 1);
        @(negedge clk);

        // add x2,x1,x1 waits on x1
        send(32'h00108133, 32'h104, w);
`ifdef DECODE_SCOREBOARD_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("raw_stall", id_valid, 0);
            @(negedge clk);
        end
        wb_pulse(5'd1);
        #1;
        chk("raw_release", id_valid, 1);
        @(negedge clk);
`endif
        wb_pulse(5'd2);

        // stall three cycles, then drain and refill in one cycle
        id_ready = 1'b0;
        send(32'h00700193, 32'h108, w);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_if_ready", if_ready, 0);
            chk("stall_rd", rd, 3);
            chk("stall_imm", imm, 7);
            chk("stall_id_pc", id_pc, 32'h108);
            @(negedge clk);
        end
        id_ready = 1'b1;
        send(32'h00900213, 32'h10C, w);
        chk("refill_same_cycle", w, 0);
        #1;
        chk("refill_rd", rd, 4);
        @(negedge clk);
        wb_pulse(5'd3);
        wb_pulse(5'd4);

        // store and branch immediates
        send(32'hFE20AE23, 32'h110, w);
        #1;
        chk("sw_imm", imm, 32'hFFFFFFFC);
        chk("sw_reg_write", reg_write, 0);
        @(negedge clk);
        send(32'hFE000FE3, 32'h114, w);
        #1;
        chk("beq_imm", imm, 32'hFFFFFFFE);
        chk("beq_reg_write", reg_write, 0);
        @(negedge clk);

        // illegal opcode, then x0 destination must never become busy
        send(32'h000000FF, 32'h118, w);
        #1;
        chk("ill_illegal", illegal, 1);
        chk("ill_reg_write", reg_write, 0);
        chk("ill_imm", imm, 0);
        @(negedge clk);
        send(32'h00000013, 32'h11C, w);
        #1;
        chk("nop_reg_write", reg_write, 0);
        chk("nop_illegal", illegal, 0);
        @(negedge clk);
        send(32'h00100293, 32'h120, w);
        #1;
        chk("x0_not_busy", id_valid, 1);
        @(negedge clk);

        // flush with a simultaneous offer; an issued writer stays busy
        send(32'h00100413, 32'h124, w);
        @(negedge clk);
        id_ready = 1'b0;
        send(32'h00100313, 32'h128, w);
        flush    = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h00200393;
        #3;
        chk("flush_if_ready", if_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        if_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("flush_slot_empty", id_valid, 0);
        @(negedge clk);
        #1;
        chk("flush_not_captured", id_valid, 0);
        @(negedge clk);
        id_ready = 1'b1;
        send(32'h000404B3, 32'h12C, w);
`ifdef DECODE_SCOREBOARD_EN
        #1;
        chk("busy_kept_after_flush", id_valid, 0);
        @(negedge clk);
`endif
        wb_pulse(5'd8);
        repeat (2) @(negedge clk);

        // reset mid-stall overrides flush, offer and writeback
        id_ready = 1'b0;
        send(32'h00A00513, 32'h130, w);
        reset    = 1'b1;
        flush    = 1'b1;
        if_valid = 1'b1;
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        @(negedge clk);
        reset    = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        chk("midrst_id_valid", id_valid, 0);
        chk("midrst_rd", rd, 0);
        chk("midrst_imm", imm, 0);
        chk("midrst_id_pc", id_pc, 0);
        @(negedge clk);

        // randomized traffic
        wb_auto  = 1'b1;
        rdy_auto = 1'b1;
        for (int k = 0; k < 250; k++) begin
            ins        = $urandom();
            ins[6:0]   = ops[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) do_flush(1'($urandom_range(0, 1)), $urandom());
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(ins, 32'h1000 + 32'(k * 4), w);
        end

        // drain
        rdy_auto = 1'b0;
        id_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        wb_auto = 1'b0;
        @(negedge clk);
        wb_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset sampled on rising clk.
REQ-003 SHALL have port if_valid, input, 1, fetch offers instruction.
REQ-004 SHALL have port if_instr, input, 32, RV32I instruction word.
REQ-005 SHALL have port if_pc, input, 32, PC of offered instruction.
REQ-006 SHALL have port if_ready, output, 1, stage accepts offer this cycle.
REQ-007 SHALL have port id_valid, output, 1, decoded instruction issuable.
REQ-008 SHALL have port id_ready, input, 1, downstream consumes this cycle.
REQ-009 SHALL have ports rs1/rs2/rd, output, 5 each, register-file address fields (bits 19:15, 24:20, 11:7).
REQ-010 SHALL have port reg_write, output, 1, instruction writes rd.
REQ-011 SHALL have port imm, output, 32, sign-extended immediate.
REQ-012 SHALL have port id_pc, output, 32, PC of held instruction.
REQ-013 SHALL have port illegal, output, 1, unsupported opcode.
REQ-014 SHALL have port flush, input, 1, discard held instruction.
REQ-015 SHALL have ports wb_valid (1) and wb_rd (5), inputs, writeback retiring rd.

Function
REQ-016 SHALL hold one-entry slot; accept = if_valid && if_ready; fire = id_valid && id_ready.
REQ-017 SHALL drive if_ready = !slot_valid || fire (combinational through id_ready).
REQ-018 SHALL decode at capture; all id outputs registered; accept-to-id_valid latency 1 cycle.
REQ-019 SHALL recognise opcodes LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; any other -> illegal=1, reg_write=0, imm=0.
REQ-020 SHALL form imm: I-type (JALR, LOAD, OP-IMM), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 zero), J (JAL, bit0=0); OP -> imm=0.
REQ-021 SHALL set reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP only when rd!=0.
REQ-022 SHALL mark uses_rs1 for all legal opcodes except LUI, AUIPC, JAL; uses_rs2 for BRANCH, STORE, OP only.
REQ-023 SHALL keep outputs stable while id_valid && !id_ready.
REQ-024 SHALL on flush clear slot_valid next cycle; flush overrides a simultaneous accept (if_ready forced 0 during flush).
REQ-025 SHALL keep scoreboard busy[31:1]; busy[0] hard-wired 0.
REQ-026 SHALL set busy[rd] on fire with reg_write=1; clear busy[wb_rd] on wb_valid; same-index set and clear in one cycle -> set wins.
REQ-027 SHALL compute hazard = slot_valid && ((uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2])) from registered busy only (no wb bypass).
REQ-028 SHALL drive id_valid = slot_valid && !hazard.
REQ-029 SHALL leave busy bits unchanged on flush (already-issued instructions still write back).

Reset
REQ-030 SHALL on reset clear slot_valid and all busy bits; rs1, rs2, rd, imm, id_pc, reg_write, illegal = 0; id_valid=0.
REQ-031 SHALL let reset override flush, accept and wb_valid in the same cycle; reset mid-stall discards held instruction.
REQ-032 SHALL drive if_ready=0 while reset asserted.

Configuration
REQ-033 SHALL compile scoreboard (REQ-025..027, REQ-029) only when DECODE_SCOREBOARD_EN defined.
REQ-034 SHALL without DECODE_SCOREBOARD_EN tie hazard=0 (downstream forwarding assumed), ignore wb_valid/wb_rd, and keep all other behaviour identical.

Verification
REQ-035 SHALL cover: reset, then if_instr=0x00500093 (addi x1,x0,5) accepted, id_ready=1 -> next cycle id_valid=1, rd=1, rs1=0, imm=5, reg_write=1.
REQ-036 SHALL cover: id_ready=0 three cycles with held instr -> outputs stable, if_ready=0; id_ready=1 -> fire, new instr accepted same cycle.
REQ-037 SHALL cover (macro on): addi x1 fires, then add x2,x1,x1 (0x00108133) -> id_valid=0 until wb_valid=1, wb_rd=1; id_valid=1 cycle after.
REQ-038 SHALL cover: sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, reg_write=0; beq with offset -2 -> imm=0xFFFFFFFE.
REQ-039 SHALL cover: flush with if_valid=1 on same cycle -> slot empty next cycle, instruction not captured, busy unchanged.
REQ-040 SHALL cover: opcode 0x7F -> illegal=1, reg_write=0; addi x0,x0,0 -> reg_write=0, busy[0] never set.
